// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the fetch-stage program counter
package pc_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } pc_state_t;

    localparam int DEFAULT_STEP       = 1;
    localparam int DEFAULT_IRQ_VECTOR = 64;

    function automatic int prog_sel_w(input int num_programs);
        return (num_programs > 1) ? $clog2(num_programs) : 1;
    endfunction

endpackage

// File: rtl/pc_irq_tracker.sv
// rtl/pc_irq_tracker.sv - interrupt rising-edge detect and single-bit pending latch
module pc_irq_tracker (
    input  logic clock,
    input  logic reset,
    input  logic interrupt,
    input  logic take,
    output logic pending
);

    logic irq_prev;
    logic pending_q;
    logic edge_seen;

    assign edge_seen = interrupt & ~irq_prev;
    // An edge arriving this cycle is visible at once so RUN can enter without delay.
    assign pending   = pending_q | edge_seen;

    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_prev  <= interrupt;
            pending_q <= 1'b0;
        end else begin
            irq_prev  <= interrupt;
            pending_q <= pending & ~take;
        end
    end

endmodule

// File: rtl/program_counter_unit.sv
// rtl/program_counter_unit.sv - parametrised fetch PC with boot table, stall and interrupt entry/return
module program_counter_unit
    import pc_pkg::*;
#(
    parameter int                            WIDTH        = 32,
    parameter int                            NUM_PROGRAMS = 4,
    parameter logic [NUM_PROGRAMS*WIDTH-1:0] BOOT_VECTORS = {WIDTH'(29), WIDTH'(14), WIDTH'(0), {WIDTH{1'b1}}},
    parameter int                            STEP         = DEFAULT_STEP,
    parameter int                            IRQ_VECTOR   = DEFAULT_IRQ_VECTOR
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [prog_sel_w(NUM_PROGRAMS)-1:0]   progr,
    input  logic                                  stall,
    input  logic                                  pc_src,
    input  logic [WIDTH-1:0]                      address,
    input  logic                                  interrupt,
    input  logic                                  eret,
    output logic [WIDTH-1:0]                      programCounter,
    output logic [WIDTH-1:0]                      epc,
    output logic                                  in_handler,
    output logic                                  irq_ack,
    output logic                                  eret_fault
);

    localparam int               PROG_SEL_W = prog_sel_w(NUM_PROGRAMS);
    localparam int               SEL_EXT_W  = PROG_SEL_W + 1;
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] IRQ_W      = WIDTH'(IRQ_VECTOR);

    pc_state_t        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             ack_q, ack_d;
    logic             fault_q, fault_d;
    logic [WIDTH-1:0] seq;
    logic [WIDTH-1:0] boot_vec;
    logic [SEL_EXT_W-1:0] progr_ext;
    logic             pending;
    logic             take;

    pc_irq_tracker u_irq_tracker (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .take      (take),
        .pending   (pending)
    );

    assign seq       = pc_src ? address : pc_q + STEP_W;
    assign progr_ext = {1'b0, progr};

    // Out-of-range selects match no slot and fall back to slot 0.
    always_comb begin
        boot_vec = BOOT_VECTORS[WIDTH-1:0];
        for (int i = 0; i < NUM_PROGRAMS; i++) begin
            if (progr_ext == SEL_EXT_W'(i)) begin
                boot_vec = BOOT_VECTORS[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        ack_d   = 1'b0;
        fault_d = 1'b0;
        take    = 1'b0;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    if (eret) begin
                        pc_d    = seq;
                        fault_d = 1'b1;
                    end else if (pending) begin
                        epc_d   = seq;
                        pc_d    = IRQ_W;
                        take    = 1'b1;
                        ack_d   = 1'b1;
                        state_d = HANDLER;
                    end else begin
                        pc_d = seq;
                    end
                end
                HANDLER: begin
                    // Pending stays set across the return so it is taken next cycle.
                    if (eret) begin
                        pc_d    = epc_q;
                        state_d = RUN;
                    end else begin
                        pc_d = seq;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            pc_q    <= boot_vec;
            epc_q   <= '0;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ack_q   <= ack_d;
            fault_q <= fault_d;
        end
    end

    assign programCounter = pc_q;
    assign epc            = epc_q;
    assign in_handler     = (state_q == HANDLER);
    assign irq_ack        = ack_q;
    assign eret_fault     = fault_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// tb/tb_program_counter_unit.sv - directed self-checking bench for program_counter_unit
module tb_program_counter_unit;

    logic        clock;
    logic        reset;
    logic [1:0]  progr;
    logic        stall;
    logic        pc_src;
    logic [31:0] address;
    logic        interrupt;
    logic        eret;
    logic [31:0] programCounter;
    logic [31:0] epc;
    logic        in_handler;
    logic        irq_ack;
    logic        eret_fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_boot [4];
    logic [31:0] exp_next [4];

    program_counter_unit dut (
        .clock          (clock),
        .reset          (reset),
        .progr          (progr),
        .stall          (stall),
        .pc_src         (pc_src),
        .address        (address),
        .interrupt      (interrupt),
        .eret           (eret),
        .programCounter (programCounter),
        .epc            (epc),
        .in_handler     (in_handler),
        .irq_ack        (irq_ack),
        .eret_fault     (eret_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        exp_boot[0] = 32'hFFFF_FFFF; exp_next[0] = 32'd0;
        exp_boot[1] = 32'd0;         exp_next[1] = 32'd1;
        exp_boot[2] = 32'd14;        exp_next[2] = 32'd15;
        exp_boot[3] = 32'd29;        exp_next[3] = 32'd30;

        reset = 1'b0; progr = 2'd0; stall = 1'b0; pc_src = 1'b0;
        address = 32'd0; interrupt = 1'b0; eret = 1'b0;

        // boot slots
        for (int p = 0; p < 4; p++) begin
            reset = 1'b0; progr = 2'(p);
            tick();
            check($sformatf("boot_pc%0d", p), programCounter, exp_boot[p]);
            check($sformatf("boot_epc%0d", p), epc, 32'd0);
            check($sformatf("boot_inh%0d", p), {31'd0, in_handler}, 32'd0);
            check($sformatf("boot_ack%0d", p), {31'd0, irq_ack}, 32'd0);
            reset = 1'b1;
            tick();
            check($sformatf("seq_pc%0d", p), programCounter, exp_next[p]);
        end

        // load and wrap
        pc_src = 1'b1; address = 32'h100;
        tick();
        check("load_100", programCounter, 32'h100);
        address = 32'hFFFF_FFFF;
        tick();
        check("load_ones", programCounter, 32'hFFFF_FFFF);
        pc_src = 1'b0;
        tick();
        check("wrap_0", programCounter, 32'd0);

        // interrupt entry and return
        pc_src = 1'b1; address = 32'd20;
        tick();
        pc_src = 1'b0;
        check("pc_20", programCounter, 32'd20);
        interrupt = 1'b1;
        tick();
        check("irq_pc", programCounter, 32'd64);
        check("irq_epc", epc, 32'd21);
        check("irq_ack1", {31'd0, irq_ack}, 32'd1);
        check("irq_inh", {31'd0, in_handler}, 32'd1);
        tick();
        check("irq_ack0", {31'd0, irq_ack}, 32'd0);
        check("h_pc65", programCounter, 32'd65);
        tick();
        tick();
        check("h_pc67", programCounter, 32'd67);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("ret_pc", programCounter, 32'd21);
        check("ret_inh", {31'd0, in_handler}, 32'd0);
        check("ret_nofault", {31'd0, eret_fault}, 32'd0);
        interrupt = 1'b0;
        tick();
        check("run_pc22", programCounter, 32'd22);

        // edge during stall
        stall = 1'b1; interrupt = 1'b1;
        tick();
        check("stall_pc1", programCounter, 32'd22);
        tick();
        check("stall_pc2", programCounter, 32'd22);
        check("stall_ack", {31'd0, irq_ack}, 32'd0);
        stall = 1'b0;
        tick();
        check("stall_entry_pc", programCounter, 32'd64);
        check("stall_entry_epc", epc, 32'd23);
        check("stall_entry_ack", {31'd0, irq_ack}, 32'd1);

        // edge in handler, then eret gives back-to-back entry
        interrupt = 1'b0;
        tick();
        interrupt = 1'b1;
        tick();
        check("nest_pc", programCounter, 32'd66);
        check("nest_ack", {31'd0, irq_ack}, 32'd0);
        check("nest_epc", epc, 32'd23);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("b2b_ret_pc", programCounter, 32'd23);
        check("b2b_ret_inh", {31'd0, in_handler}, 32'd0);
        tick();
        check("b2b_pc", programCounter, 32'd64);
        check("b2b_epc", epc, 32'd24);
        check("b2b_ack", {31'd0, irq_ack}, 32'd1);
        eret = 1'b1; interrupt = 1'b0;
        tick();
        eret = 1'b0;
        check("b2b_ret2", programCounter, 32'd24);

        // eret in RUN
        pc_src = 1'b1; address = 32'd7;
        tick();
        pc_src = 1'b0; eret = 1'b1;
        tick();
        eret = 1'b0;
        check("fault_pc", programCounter, 32'd8);
        check("fault_1", {31'd0, eret_fault}, 32'd1);
        check("fault_inh", {31'd0, in_handler}, 32'd0);
        tick();
        check("fault_0", {31'd0, eret_fault}, 32'd0);
        check("fault_pc9", programCounter, 32'd9);

        // reset inside handler with a pending edge
        interrupt = 1'b1;
        tick();
        check("h2_pc", programCounter, 32'd64);
        interrupt = 1'b0;
        tick();
        interrupt = 1'b1;
        tick();
        reset = 1'b0; progr = 2'd2;
        tick();
        check("hrst_pc", programCounter, 32'd14);
        check("hrst_epc", epc, 32'd0);
        check("hrst_inh", {31'd0, in_handler}, 32'd0);
        reset = 1'b1;
        tick();
        check("hrst_pc15", programCounter, 32'd15);
        check("hrst_noack", {31'd0, irq_ack}, 32'd0);
        tick();
        check("hrst_noentry", programCounter, 32'd16);
        check("hrst_inh2", {31'd0, in_handler}, 32'd0);

        // reset beats stall
        stall = 1'b1; reset = 1'b0; progr = 2'd3;
        tick();
        check("rst_stall_pc", programCounter, 32'd29);
        reset = 1'b1; stall = 1'b0;
        tick();
        check("rst_stall_pc30", programCounter, 32'd30);

        // several edges while stalled merge into one entry
        stall = 1'b1;
        interrupt = 1'b0; tick();
        interrupt = 1'b1; tick();
        interrupt = 1'b0; tick();
        interrupt = 1'b1; tick();
        check("merge_hold", programCounter, 32'd30);
        stall = 1'b0;
        tick();
        check("merge_pc", programCounter, 32'd64);
        check("merge_epc", epc, 32'd31);
        check("merge_ack", {31'd0, irq_ack}, 32'd1);
        tick();
        check("merge_ack0", {31'd0, irq_ack}, 32'd0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("merge_ret", programCounter, 32'd31);
        tick();
        check("merge_once_pc", programCounter, 32'd32);
        check("merge_once_inh", {31'd0, in_handler}, 32'd0);
        check("merge_once_ack", {31'd0, irq_ack}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
